// File: rtl/adc_spi_responder.sv
// SPI responder for the 2-channel 12-bit ADC bus. It decodes the master's command frame and
// shifts back the selected result, or the pseudo-differential result, on adc_data_out.
module adc_spi_responder #(
  parameter int SYNC_STAGES = 2  // minimum 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        adc_cs_n,
  input  logic        adc_sclk,
  input  logic        adc_din,
  input  logic [11:0] ch0_value,
  input  logic [11:0] ch1_value,
  output logic        adc_data_out,
  output logic        frame_done,
  output logic        frame_error,
  output logic        last_channel,
  output logic [7:0]  frame_count
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_CMD,
    ST_NULL,
    ST_DATA_MSB,
    ST_DATA_LSB,
    ST_TAIL
  } state_t;

  // Each synchronizer stage holds {din, sclk, cs_n}.
  logic [SYNC_STAGES-1:0][2:0] sync_q;
  logic cs_s, sclk_s, din_s;

  logic cs_prev_q, sclk_prev_q;
  logic cs_rise_q, cs_fall_q, sclk_rise_q, sclk_fall_q;
  logic din_q;

  state_t      state_q, state_d;
  logic [1:0]  cmd_cnt_q, cmd_cnt_d;
  logic        sgl_q, sgl_d;
  logic        odd_q, odd_d;
  logic        msbf_q, msbf_d;
  logic [11:0] sample_q, sample_d;
  logic [3:0]  idx_q, idx_d;
  logic        data_out_q, data_out_d;
  logic        frame_done_q, frame_done_d;
  logic        frame_error_q, frame_error_d;
  logic        last_channel_q, last_channel_d;
  logic [7:0]  frame_count_q, frame_count_d;

  logic [12:0] diff01, diff10;
  logic [11:0] sel_sample;
  logic        complete;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{3'b001}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], {adc_din, adc_sclk, adc_cs_n}};
    end
  end

  assign cs_s   = sync_q[SYNC_STAGES-1][0];
  assign sclk_s = sync_q[SYNC_STAGES-1][1];
  assign din_s  = sync_q[SYNC_STAGES-1][2];

  // Edge pulses are registered, so the FSM acts one cycle after the edge is seen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_prev_q   <= 1'b1;
      sclk_prev_q <= 1'b0;
      cs_rise_q   <= 1'b0;
      cs_fall_q   <= 1'b0;
      sclk_rise_q <= 1'b0;
      sclk_fall_q <= 1'b0;
      din_q       <= 1'b0;
    end else begin
      cs_prev_q   <= cs_s;
      sclk_prev_q <= sclk_s;
      cs_rise_q   <= cs_s & ~cs_prev_q;
      cs_fall_q   <= ~cs_s & cs_prev_q;
      sclk_rise_q <= sclk_s & ~sclk_prev_q;
      sclk_fall_q <= ~sclk_s & sclk_prev_q;
      din_q       <= din_s;
    end
  end

  // The borrow bit of each 13-bit difference tells whether the subtraction would go negative.
  always_comb begin
    diff01 = {1'b0, ch0_value} - {1'b0, ch1_value};
    diff10 = {1'b0, ch1_value} - {1'b0, ch0_value};
    sel_sample = 12'd0;
    if (sgl_q) begin
      sel_sample = odd_q ? ch1_value : ch0_value;
    end else if (!odd_q) begin
      sel_sample = diff01[12] ? 12'd0 : diff01[11:0];
    end else begin
      sel_sample = diff10[12] ? 12'd0 : diff10[11:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      cmd_cnt_q      <= 2'd0;
      sgl_q          <= 1'b0;
      odd_q          <= 1'b0;
      msbf_q         <= 1'b0;
      sample_q       <= 12'd0;
      idx_q          <= 4'd0;
      data_out_q     <= 1'b0;
      frame_done_q   <= 1'b0;
      frame_error_q  <= 1'b0;
      last_channel_q <= 1'b0;
      frame_count_q  <= 8'd0;
    end else begin
      state_q        <= state_d;
      cmd_cnt_q      <= cmd_cnt_d;
      sgl_q          <= sgl_d;
      odd_q          <= odd_d;
      msbf_q         <= msbf_d;
      sample_q       <= sample_d;
      idx_q          <= idx_d;
      data_out_q     <= data_out_d;
      frame_done_q   <= frame_done_d;
      frame_error_q  <= frame_error_d;
      last_channel_q <= last_channel_d;
      frame_count_q  <= frame_count_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cmd_cnt_d      = cmd_cnt_q;
    sgl_d          = sgl_q;
    odd_d          = odd_q;
    msbf_d         = msbf_q;
    sample_d       = sample_q;
    idx_d          = idx_q;
    data_out_d     = data_out_q;
    frame_done_d   = 1'b0;
    frame_error_d  = 1'b0;
    last_channel_d = last_channel_q;
    frame_count_d  = frame_count_q;
    complete       = 1'b0;

    // A CS rise takes priority over any sclk edge that is detected in the same cycle.
    if (cs_rise_q) begin
      state_d    = ST_IDLE;
      data_out_d = 1'b0;
      if (state_q inside {ST_CMD, ST_NULL, ST_DATA_MSB, ST_DATA_LSB}) begin
        frame_error_d = 1'b1;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          data_out_d = 1'b0;
          if (cs_fall_q) begin
            state_d = ST_START;
          end
        end
        ST_START: begin
          if (sclk_rise_q && din_q) begin
            state_d   = ST_CMD;
            cmd_cnt_d = 2'd0;
          end
        end
        ST_CMD: begin
          if (sclk_rise_q) begin
            cmd_cnt_d = cmd_cnt_q + 2'd1;
            case (cmd_cnt_q)
              2'd0:    sgl_d = din_q;
              2'd1:    odd_d = din_q;
              default: begin
                msbf_d  = din_q;
                state_d = ST_NULL;
              end
            endcase
          end
        end
        ST_NULL: begin
          if (sclk_fall_q) begin
            sample_d   = sel_sample;
            data_out_d = 1'b0;
            idx_d      = 4'd11;
            state_d    = ST_DATA_MSB;
          end
        end
        ST_DATA_MSB: begin
          if (sclk_fall_q) begin
            data_out_d = sample_q[idx_q];
            if (idx_q == 4'd0) begin
              if (msbf_q) begin
                state_d  = ST_TAIL;
                complete = 1'b1;
              end else begin
                state_d = ST_DATA_LSB;
                idx_d   = 4'd1;
              end
            end else begin
              idx_d = idx_q - 4'd1;
            end
          end
        end
        ST_DATA_LSB: begin
          if (sclk_fall_q) begin
            data_out_d = sample_q[idx_q];
            if (idx_q == 4'd11) begin
              state_d  = ST_TAIL;
              complete = 1'b1;
            end else begin
              idx_d = idx_q + 4'd1;
            end
          end
        end
        ST_TAIL: begin
          if (sclk_fall_q) begin
            data_out_d = 1'b0;
          end
        end
        default: begin
          state_d    = ST_IDLE;
          data_out_d = 1'b0;
        end
      endcase
    end

    if (complete) begin
      frame_done_d   = 1'b1;
      frame_count_d  = frame_count_q + 8'd1;
      last_channel_d = odd_q;
    end
  end

  assign adc_data_out = data_out_q;
  assign frame_done   = frame_done_q;
  assign frame_error  = frame_error_q;
  assign last_channel = last_channel_q;
  assign frame_count  = frame_count_q;

endmodule

// File: tb/tb_adc_spi_responder.sv
// Directed and randomized SPI frames against a bit-list reference model of the ADC responder.
module tb_adc_spi_responder;

  localparam int HALF = 6;  // sclk half period in clk cycles

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cs_n = 1'b1;
  logic        sclk = 1'b0;
  logic        din = 1'b0;
  logic [11:0] ch0 = 12'd0;
  logic [11:0] ch1 = 12'd0;
  logic        miso, frame_done, frame_error, last_channel;
  logic [7:0]  frame_count;

  int vec_cnt = 0;
  int err_cnt = 0;
  int done_pulses = 0;
  int err_pulses = 0;
  int frames_done = 0;
  bit last_model = 1'b0;

  adc_spi_responder #(.SYNC_STAGES(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .adc_cs_n     (cs_n),
    .adc_sclk     (sclk),
    .adc_din      (din),
    .ch0_value    (ch0),
    .ch1_value    (ch1),
    .adc_data_out (miso),
    .frame_done   (frame_done),
    .frame_error  (frame_error),
    .last_channel (last_channel),
    .frame_count  (frame_count)
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (frame_done) done_pulses++;
      if (frame_error) err_pulses++;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] ref_sample(input bit sgl, input bit odd,
                                             input logic [11:0] a, input logic [11:0] b);
    int ia, ib;
    ia = int'(a);
    ib = int'(b);
    if (sgl) return odd ? b : a;
    if (!odd) return (ia >= ib) ? 12'(ia - ib) : 12'd0;
    return (ib >= ia) ? 12'(ib - ia) : 12'd0;
  endfunction

  // abort_at / rst_at: sclk cycle (0-based) during whose high phase CS is raised or rst pulsed; -1 = never.
  task automatic run_frame(input bit sgl, input bit odd, input bit msbf, input int lead,
                           input int ncyc, input int abort_at, input int rst_at,
                           input logic [11:0] c0, input logic [11:0] c1, input bit chg);
    logic [11:0] smp;
    bit q[$];
    bit cmd[$];
    int ncmd, len, j, d0, e0;
    bit exp_b, aborted, complete, err_exp;
    ch0 = c0;
    ch1 = c1;
    smp = ref_sample(sgl, odd, c0, c1);
    len = msbf ? 12 : 23;
    repeat (lead) cmd.push_back(1'b0);
    cmd.push_back(1'b1);
    cmd.push_back(sgl);
    cmd.push_back(odd);
    cmd.push_back(msbf);
    ncmd = lead + 4;
    q.push_back(1'b0);
    for (int i = 11; i >= 0; i--) q.push_back(smp[i]);
    if (!msbf) for (int i = 1; i <= 11; i++) q.push_back(smp[i]);
    d0 = done_pulses;
    e0 = err_pulses;
    aborted = 1'b0;
    cs_n = 1'b0;
    wait_clk(6);
    for (int k = 0; k < ncyc; k++) begin
      din = (k < ncmd) ? cmd[k] : 1'b0;
      wait_clk(HALF);
      j = k - ncmd;
      exp_b = (j >= 0 && j < q.size()) ? q[j] : 1'b0;
      chk($sformatf("miso_k%0d", k), 32'(miso), 32'(exp_b));
      if (chg && j == 1) begin
        ch0 = 12'hFFF;
        ch1 = 12'hFFF;
      end
      sclk = 1'b1;
      if (k == rst_at) begin
        wait_clk(2);
        chk("pre_rst_miso", 32'(miso), 32'(exp_b));
        #3 rst = 1'b1;
        #1;
        chk("rst_miso", 32'(miso), 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);
        chk("rst_error", 32'(frame_error), 32'd0);
        chk("rst_last_ch", 32'(last_channel), 32'd0);
        chk("rst_count", 32'(frame_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cs_n = 1'b1;
        sclk = 1'b0;
        din = 1'b0;
        frames_done = 0;
        last_model = 1'b0;
        wait_clk(10);
        chk("rst_no_done", 32'(done_pulses - d0), 32'd0);
        chk("rst_no_error", 32'(err_pulses - e0), 32'd0);
        return;
      end
      if (k == abort_at) begin
        wait_clk(3);
        cs_n = 1'b1;
        aborted = 1'b1;
        wait_clk(HALF);
        sclk = 1'b0;
        break;
      end
      wait_clk(HALF);
      sclk = 1'b0;
    end
    if (!aborted) begin
      wait_clk(HALF);
      cs_n = 1'b1;
    end
    din = 1'b0;
    wait_clk(8);
    if (aborted) begin
      err_exp  = (abort_at >= lead) && (abort_at <= ncmd + len - 1);
      complete = (abort_at >= ncmd + len);
    end else begin
      err_exp  = (ncyc >= lead + 1) && (ncyc <= ncmd + len - 1);
      complete = (ncyc >= ncmd + len);
    end
    if (complete) begin
      frames_done++;
      last_model = odd;
    end
    chk("idle_miso", 32'(miso), 32'd0);
    chk("done_pulses", 32'(done_pulses - d0), complete ? 32'd1 : 32'd0);
    chk("error_pulses", 32'(err_pulses - e0), err_exp ? 32'd1 : 32'd0);
    chk("frame_count", 32'(frame_count), 32'(frames_done % 256));
    chk("last_channel", 32'(last_channel), 32'(last_model));
  endtask

  initial begin
    bit s, o, m;
    int ld, nc, ab;
    wait_clk(3);
    chk("reset_miso", 32'(miso), 32'd0);
    chk("reset_done", 32'(frame_done), 32'd0);
    chk("reset_error", 32'(frame_error), 32'd0);
    chk("reset_last_ch", 32'(last_channel), 32'd0);
    chk("reset_count", 32'(frame_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    wait_clk(4);

    run_frame(1'b1, 1'b0, 1'b1, 0, 20, -1, -1, 12'hA5C, 12'h000, 1'b0);
    run_frame(1'b1, 1'b1, 1'b0, 0, 30, -1, -1, 12'h000, 12'h801, 1'b0);
    run_frame(1'b0, 1'b0, 1'b1, 0, 18, -1, -1, 12'h100, 12'h300, 1'b0);
    run_frame(1'b0, 1'b1, 1'b1, 0, 18, -1, -1, 12'h100, 12'h300, 1'b0);
    run_frame(1'b1, 1'b0, 1'b1, 2, 22, -1, -1, 12'hA5C, 12'h3C3, 1'b1);
    run_frame(1'b1, 1'b0, 1'b1, 0, 20, 9, -1, 12'hA5C, 12'h000, 1'b0);
    run_frame(1'b1, 1'b1, 1'b1, 0, 18, -1, -1, 12'h123, 12'h9B7, 1'b0);

    for (int it = 0; it < 320 && frames_done < 257; it++) begin
      s  = 1'($urandom_range(0, 1));
      o  = 1'($urandom_range(0, 1));
      m  = ($urandom_range(0, 3) != 0);
      ld = int'($urandom_range(0, 2));
      nc = ld + 4 + (m ? 12 : 23) + int'($urandom_range(0, 1));
      ab = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, nc - 1)) : -1;
      run_frame(s, o, m, ld, nc, ab, -1, 12'($urandom), 12'($urandom), 1'b0);
    end

    run_frame(1'b1, 1'b1, 1'b1, 0, 18, -1, -1, 12'h0F0, 12'hFFF, 1'b0);
    run_frame(1'b1, 1'b0, 1'b1, 0, 20, -1, 7, 12'hFFF, 12'h000, 1'b0);
    run_frame(1'b1, 1'b0, 1'b1, 0, 18, -1, -1, 12'h5A5, 12'h000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
